// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: LSB-first shifting with valid strobe and end-of-word pulse.
// Optional even-parity bit after each word when PISO_PARITY_EN is defined.
module piso_tx #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load,
    output logic             Ready,
    output logic             O,
    output logic             O_valid,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        even_parity = ^word;
    endfunction
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;

    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
`endif

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] sreg_r, sreg_s;
    logic             valid_r, valid_s;
    logic             done_r, done_s;
    logic             ready_r, ready_s;
    logic             accept_s;
`ifdef PISO_PARITY_EN
    logic             par_r, par_s;
`endif

    // Next-state and next-output computation; outputs are registered one cycle ahead.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        sreg_s   = sreg_r;
        valid_s  = 1'b0;
        done_s   = 1'b0;
        ready_s  = 1'b1;
`ifdef PISO_PARITY_EN
        par_s    = par_r;
`endif
        accept_s = Load & ready_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                    cnt_s   = {CW{1'b0}};
                    sreg_s  = Din;
                    valid_s = 1'b1;
                    ready_s = 1'b0;
`ifdef PISO_PARITY_EN
                    par_s   = even_parity(Din);
`endif
                end else begin
                    sreg_s = {WIDTH{1'b0}};
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_CNT) begin
`ifdef PISO_PARITY_EN
                    // Parity bit takes over bit 0 so O stays a plain register bit.
                    state_s = PAR;
                    cnt_s   = cnt_r + CNT_ONE;
                    sreg_s  = {{(WIDTH-1){1'b0}}, par_r};
                    valid_s = 1'b1;
                    done_s  = 1'b1;
                    ready_s = 1'b1;
`else
                    if (accept_s) begin
                        cnt_s   = {CW{1'b0}};
                        sreg_s  = Din;
                        valid_s = 1'b1;
                        ready_s = 1'b0;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = {CW{1'b0}};
                        sreg_s  = {WIDTH{1'b0}};
                    end
`endif
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    sreg_s  = {1'b0, sreg_r[WIDTH-1:1]};
                    valid_s = 1'b1;
`ifdef PISO_PARITY_EN
                    done_s  = 1'b0;
                    ready_s = 1'b0;
`else
                    done_s  = (cnt_r == PRE_LAST);
                    ready_s = (cnt_r == PRE_LAST);
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                if (accept_s) begin
                    state_s = SHIFT;
                    cnt_s   = {CW{1'b0}};
                    sreg_s  = Din;
                    par_s   = even_parity(Din);
                    valid_s = 1'b1;
                    ready_s = 1'b0;
                end else begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                    sreg_s  = {WIDTH{1'b0}};
                end
            end
`endif
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
                sreg_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers; Reset overrides everything including Load.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            sreg_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
`ifdef PISO_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sreg_r  <= sreg_s;
            valid_r <= valid_s;
            done_r  <= done_s;
            ready_r <= ready_s;
`ifdef PISO_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

    assign O       = sreg_r[0];
    assign O_valid = valid_r;
    assign Done    = done_r;
    assign Ready   = ready_r;

endmodule
